// File: rtl/ifetch_prefetch_queue_if.sv
// Fetch-unit bus: instruction-memory request/response plus the IF/ID handshake.
// The master side is the prefetch queue; the slave side is memory and decode.
interface ifetch_prefetch_queue_if;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_inst;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_inst,
        output out_valid, out_pc, out_inst,
        input  out_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_inst,
        input  out_valid, out_pc, out_inst,
        output out_ready
    );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch into an in-order FIFO,
// with flush-and-restart on a taken branch.
module ifetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    reset,
    ifetch_prefetch_queue_if.master bus,
    input  logic                    redirect_valid,
    input  logic [63:0]             redirect_pc,
    output logic [$clog2(DEPTH):0]  q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } entry_t;

    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    entry_t      mem_q [DEPTH];
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] rsp_pc_q, rsp_pc_d;
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    cnt_t        count_q, count_d;
    cnt_t        outst_q, outst_d;
    cnt_t        drop_cnt_q, drop_cnt_d;

    logic        req_fire;
    logic        rsp_ok;
    logic        push;
    logic        pop;
    logic [CW:0] credit_used;
    logic [63:0] target_pc;
    logic        redirect_pc_unused;

    assign redirect_pc_unused = ^redirect_pc[1:0];
    assign target_pc          = {redirect_pc[63:2], 2'b00};

    // Queued entries plus in-flight requests may never exceed DEPTH, so a
    // returning word always has a slot waiting for it.
    assign credit_used       = {1'b0, count_q} + {1'b0, outst_q};
    assign bus.mem_req_valid = reset & ~redirect_valid & (credit_used < CREDITS);
    assign bus.mem_req_addr  = fetch_pc_q;
    assign req_fire          = bus.mem_req_valid & bus.mem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok = bus.mem_rsp_valid & (outst_q != '0);
    assign push   = rsp_ok & ~redirect_valid & (drop_cnt_q == '0);
    assign pop    = bus.out_valid & bus.out_ready & ~redirect_valid;

    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = bus.out_valid ? mem_q[head_q].pc   : 64'h0;
    assign bus.out_inst  = bus.out_valid ? mem_q[head_q].inst : NOP_INST;
    assign q_count       = count_q;

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through this block
        // leaves a variable unassigned, which would otherwise infer a latch.
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_cnt_d = drop_cnt_q;

        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            // Everything still in flight after this cycle belongs to the old path.
            outst_d    = outst_q - cnt_t'(rsp_ok);
            drop_cnt_d = outst_q - cnt_t'(rsp_ok);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            outst_d = outst_q + cnt_t'(req_fire) - cnt_t'(rsp_ok);
            if (rsp_ok && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - cnt_t'(1);
            end
            if (push) begin
                tail_d   = tail_q + ptr_t'(1);
                rsp_pc_d = rsp_pc_q + 64'd4;
            end
            if (pop) begin
                head_d = head_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state flops use non-blocking assignments so every flop samples
            // the pre-edge values regardless of statement order.
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset; an empty queue masks it
    // on out_*, and leaving it reset-free lets it map onto plain RAM/regfile cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= entry_t'{pc: rsp_pc_q, inst: bus.mem_rsp_inst};
        end
    end
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Bench for ifetch_prefetch_queue: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model and a latency memory.
module tb_ifetch_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   redirect_valid;
    logic [63:0]            redirect_pc;
    logic [$clog2(DEPTH):0] q_count;

    ifetch_prefetch_queue_if bus ();

    ifetch_prefetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .q_count       (q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int unsigned due;
    } pend_t;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model
    pend_t       pend[$];
    int unsigned cyc = 0;
    int          n_acc = 0;

    // reference model
    logic [63:0] m_q[$];
    logic [63:0] m_fetch, m_rsp, stream_pc;
    int          m_outst, m_drop;

    // stimulus knobs
    int          cfg_lat_min = 1, cfg_lat_max = 1;
    int          cfg_ready_pct = 100, cfg_oready_pct = 100, cfg_redir_pm = 0;
    logic        force_redir = 1'b0;
    logic [63:0] force_pc = '0;
    logic        inject = 1'b0;

    // last sampled DUT outputs
    logic                   s_req_valid, s_out_valid;
    logic [63:0]            s_req_addr, s_out_pc;
    logic [31:0]            s_out_inst;
    logic [$clog2(DEPTH):0] s_q_count;

    function automatic logic [31:0] inst_of(logic [63:0] a);
        return a[33:2] ^ {a[63:34], 2'b11};
    endfunction

    function automatic logic [63:0] rand_pc();
        if ($urandom_range(3) == 0)
            return {32'hFFFF_FFFF, 24'hFFFF_FF, 8'($urandom_range(255))};
        return {$urandom, $urandom};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        pend.delete();
        m_fetch   = RESET_PC;
        m_rsp     = RESET_PC;
        stream_pc = RESET_PC;
        m_outst   = 0;
        m_drop    = 0;
        n_acc     = 0;
    endtask

    task automatic idle_inputs();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_inst  = '0;
        bus.out_ready     = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
    endtask

    // Asserts reset right now, checks the outputs clear at once, releases on a negedge.
    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_req_valid", bus.mem_req_valid, 0);
        check("rst_q_count", q_count, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_inst", bus.out_inst, NOP_INST);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step();
        logic        exp_rv, rsp_ok, fire, from_pend;
        logic [63:0] tgt;
        @(posedge clk);
        #1;
        bus.mem_req_ready = ($urandom_range(99) < cfg_ready_pct);
        bus.out_ready     = ($urandom_range(99) < cfg_oready_pct);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else if ($urandom_range(999) < cfg_redir_pm) begin
            redirect_valid = 1'b1;
            redirect_pc    = rand_pc();
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = rand_pc();
        end
        from_pend = (pend.size() > 0) && (pend[0].due <= cyc);
        if (from_pend) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_inst  = inst_of(pend[0].addr);
        end else begin
            bus.mem_rsp_valid = inject;
            bus.mem_rsp_inst  = $urandom;
        end
        inject = 1'b0;
        #1;
        s_req_valid = bus.mem_req_valid;
        s_req_addr  = bus.mem_req_addr;
        s_out_valid = bus.out_valid;
        s_out_pc    = bus.out_pc;
        s_out_inst  = bus.out_inst;
        s_q_count   = q_count;

        exp_rv = !redirect_valid && (m_q.size() + m_outst < DEPTH);
        check("req_valid", s_req_valid, exp_rv);
        if (exp_rv) check("req_addr", s_req_addr, m_fetch);
        check("out_valid", s_out_valid, m_q.size() != 0);
        check("out_pc", s_out_pc, (m_q.size() != 0) ? m_q[0] : 64'h0);
        check("out_inst", s_out_inst, (m_q.size() != 0) ? inst_of(m_q[0]) : NOP_INST);
        check("q_count", s_q_count, m_q.size());
        check("credit_bound", (int'(s_q_count) + pend.size()) <= DEPTH, 1);

        if (from_pend) void'(pend.pop_front());
        if (s_req_valid && bus.mem_req_ready) begin
            pend.push_back(pend_t'{addr: s_req_addr,
                                   due: cyc + $urandom_range(cfg_lat_max, cfg_lat_min)});
            n_acc++;
        end

        rsp_ok = bus.mem_rsp_valid && (m_outst > 0);
        fire   = exp_rv && bus.mem_req_ready;
        if (redirect_valid) begin
            tgt       = {redirect_pc[63:2], 2'b00};
            m_q.delete();
            m_fetch   = tgt;
            m_rsp     = tgt;
            stream_pc = tgt;
            m_outst   = m_outst - int'(rsp_ok);
            m_drop    = m_outst;
        end else begin
            if (m_q.size() != 0 && bus.out_ready) begin
                check("stream_pc", s_out_pc, stream_pc);
                stream_pc = stream_pc + 64'd4;
                void'(m_q.pop_front());
            end
            if (fire) begin
                m_fetch = m_fetch + 64'd4;
                m_outst++;
            end
            if (rsp_ok) begin
                m_outst--;
                if (m_drop > 0) m_drop--;
                else begin
                    m_q.push_back(m_rsp);
                    m_rsp = m_rsp + 64'd4;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        idle_inputs();
        #3;
        do_reset();

        // Streaming with a 1-cycle memory and a free-running consumer.
        step();
        check("p1_req0_valid", s_req_valid, 1);
        check("p1_req0_addr", s_req_addr, 64'h0);
        step();
        check("p1_req1_addr", s_req_addr, 64'h4);
        for (int k = 2; k < 8; k++) begin
            step();
            check("p1_out_valid", s_out_valid, 1);
            check("p1_out_pc", s_out_pc, 64'(4 * (k - 2)));
        end

        // Stalled consumer fills the queue, then one pop frees exactly one credit.
        do_reset();
        cfg_oready_pct = 0;
        repeat (6) step();
        check("p2_req_stopped", s_req_valid, 0);
        check("p2_full", s_q_count, 4);
        check("p2_head_pc", s_out_pc, 64'h0);
        check("p2_issued", n_acc, 4);
        cfg_oready_pct = 100;
        step();
        cfg_oready_pct = 0;
        step();
        check("p2_refill_valid", s_req_valid, 1);
        check("p2_refill_addr", s_req_addr, 64'h10);
        repeat (2) step();
        check("p2_issued_one_more", n_acc, 5);
        check("p2_full_again", s_q_count, 4);
        check("p2_new_head", s_out_pc, 64'h4);

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        cfg_lat_min = 3; cfg_lat_max = 3; cfg_oready_pct = 100;
        repeat (2) step();
        force_redir = 1'b1; force_pc = 64'h100;
        step();
        check("p3_no_req_on_redir", s_req_valid, 0);
        step();
        check("p3_restart_addr", s_req_addr, 64'h100);
        repeat (2) step();
        check("p3_dropped", s_q_count, 0);
        for (int i = 0; i < 20 && !s_out_valid; i++) step();
        check("p3_first_pc", s_out_pc, 64'h100);

        // Response lands in the redirect cycle; misaligned target.
        do_reset();
        cfg_lat_min = 2; cfg_lat_max = 2; cfg_oready_pct = 0;
        repeat (2) step();
        force_redir = 1'b1; force_pc = 64'h203;
        step();
        step();
        check("p4_aligned_addr", s_req_addr, 64'h200);
        for (int i = 0; i < 20 && !s_out_valid; i++) step();
        check("p4_first_pc", s_out_pc, 64'h200);
        for (int i = 0; i < 20 && s_q_count != 3; i++) step();
        check("p5_three_queued", s_q_count, 3);

        // Mid-stream reset, then a stray response with nothing outstanding.
        do_reset();
        cfg_ready_pct = 0;
        inject = 1'b1;
        step();
        cfg_ready_pct = 100;
        step();
        check("p5_stray_ignored", s_q_count, 0);
        check("p5_restart_valid", s_req_valid, 1);
        check("p5_restart_addr", s_req_addr, RESET_PC);

        // Randomized traffic.
        cfg_lat_min = 1; cfg_lat_max = 4;
        cfg_ready_pct = 70; cfg_oready_pct = 60; cfg_redir_pm = 20;
        repeat (3000) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
